// File: rtl/pipe_hazard_if.sv
// Pipeline-control bundle between the core datapath and pipe_hazard_ctrl.
// The master drives hazard inputs and the slave (controller) drives stage enables.
interface pipe_hazard_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_branch_taken;
    logic                  imem_ready;
    logic                  mem_access;
    logic                  dmem_ready;

    logic                  pc_we;
    logic                  if_id_we;
    logic                  if_id_flush;
    logic                  id_ex_we;
    logic                  id_ex_bubble;
    logic                  ex_mem_hold;
    logic                  imem_timeout;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               ex_branch_taken, imem_ready, mem_access, dmem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_hold,
               imem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               ex_branch_taken, imem_ready, mem_access, dmem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_hold,
               imem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use, branch redirect,
// imem wait and dmem wait, with Mealy stage enables and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned IMEM_TIMEOUT = 7,
    parameter int unsigned CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_hazard_if.slave bus
);
    localparam int unsigned FLUSH_W = 3;
    localparam int unsigned IMEM_W  = 8;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_IWAIT = 2'd2;

    localparam logic [REG_ADDR_W-1:0] RD_ZERO = '0;

    logic [1:0]         state_q, state_n;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_n;
    logic [IMEM_W-1:0]  imem_cnt_q, imem_cnt_n;
    logic               timeout_q, timeout_n;
    logic [CNT_W-1:0]   stall_q;

    logic pc_we_c, if_id_we_c, if_id_flush_c, id_ex_we_c, id_ex_bubble_c, ex_mem_hold_c;
    logic dstall, lduse, ifwait;

    assign dstall = bus.mem_access & ~bus.dmem_ready;
    assign lduse  = bus.ex_mem_read & (bus.ex_rd != RD_ZERO) &
                    ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
    assign ifwait = ~bus.imem_ready;

    // State, counters and sticky timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            imem_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            flush_cnt_q <= flush_cnt_n;
            imem_cnt_q  <= imem_cnt_n;
            timeout_q   <= timeout_n;
        end
    end

    // Counts every post-reset cycle in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!pc_we_c && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    // Hazard priority: dstall > branch > lduse > flush squash > ifwait > normal.
    always_comb begin
        pc_we_c        = 1'b1;
        if_id_we_c     = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_we_c     = 1'b1;
        id_ex_bubble_c = 1'b0;
        ex_mem_hold_c  = 1'b0;
        state_n        = state_q;
        flush_cnt_n    = flush_cnt_q;
        imem_cnt_n     = imem_cnt_q;
        timeout_n      = timeout_q;

        if (dstall) begin
            pc_we_c       = 1'b0;
            if_id_we_c    = 1'b0;
            id_ex_we_c    = 1'b0;
            ex_mem_hold_c = 1'b1;
        end else if (bus.ex_branch_taken) begin
            if_id_we_c     = 1'b0;
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            imem_cnt_n     = '0;
            if (FLUSH_CYCLES > 1) begin
                state_n     = ST_FLUSH;
                flush_cnt_n = FLUSH_W'(FLUSH_CYCLES - 1);
            end else begin
                state_n     = ST_RUN;
                flush_cnt_n = '0;
            end
        end else if (lduse) begin
            pc_we_c        = 1'b0;
            if_id_we_c     = 1'b0;
            id_ex_bubble_c = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            pc_we_c       = bus.imem_ready;
            if_id_we_c    = 1'b0;
            if_id_flush_c = 1'b1;
            if (bus.imem_ready) begin
                if (flush_cnt_q <= FLUSH_W'(1)) begin
                    flush_cnt_n = '0;
                    state_n     = ST_RUN;
                end else begin
                    flush_cnt_n = flush_cnt_q - FLUSH_W'(1);
                end
            end
        end else if (ifwait) begin
            pc_we_c       = 1'b0;
            if_id_we_c    = 1'b0;
            if_id_flush_c = 1'b1;
            state_n       = ST_IWAIT;
            if (imem_cnt_q != '1) begin
                imem_cnt_n = imem_cnt_q + IMEM_W'(1);
            end
            if (imem_cnt_n >= IMEM_W'(IMEM_TIMEOUT)) begin
                timeout_n = 1'b1;
            end
        end else begin
            state_n    = ST_RUN;
            imem_cnt_n = '0;
        end

        // Hold the pipeline in a safe squash pattern while reset is asserted.
        if (!rst_n) begin
            pc_we_c        = 1'b0;
            if_id_we_c     = 1'b0;
            if_id_flush_c  = 1'b1;
            id_ex_we_c     = 1'b1;
            id_ex_bubble_c = 1'b1;
            ex_mem_hold_c  = 1'b0;
        end
    end

    assign bus.pc_we        = pc_we_c;
    assign bus.if_id_we     = if_id_we_c;
    assign bus.if_id_flush  = if_id_flush_c;
    assign bus.id_ex_we     = id_ex_we_c;
    assign bus.id_ex_bubble = id_ex_bubble_c;
    assign bus.ex_mem_hold  = ex_mem_hold_c;
    assign bus.imem_timeout = timeout_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected controls,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    // Control vector order: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_hold}
    localparam logic [5:0] C_NORM = 6'b110100;
    localparam logic [5:0] C_RST  = 6'b001110;
    localparam logic [5:0] C_BR   = 6'b101110;
    localparam logic [5:0] C_LDU  = 6'b000110;
    localparam logic [5:0] C_IFW  = 6'b001100;
    localparam logic [5:0] C_FLR  = 6'b101100;
    localparam logic [5:0] C_DST  = 6'b000001;

    typedef struct {
        logic [5:0]    ctl;
        logic          to;
        logic [CW-1:0] st;
        string         nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .REG_ADDR_W(RW), .FLUSH_CYCLES(3), .IMEM_TIMEOUT(7), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    exp_t          sbq[$];
    int            checks   = 0;
    int            failures = 0;
    logic [CW-1:0] tb_stall;

    function automatic logic [5:0] ctl_now();
        return {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_we,
                bus.id_ex_bubble, bus.ex_mem_hold};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check({e.nm, ".ctl"},     32'(ctl_now()),          32'(e.ctl));
            check({e.nm, ".timeout"}, 32'(bus.imem_timeout),   32'(e.to));
            check({e.nm, ".stall"},   32'(bus.stall_cycles),   32'(e.st));
        end
    end

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_rd = '0; bus.ex_branch_taken = 1'b0;
        bus.imem_ready = 1'b1; bus.mem_access = 1'b0; bus.dmem_ready = 1'b1;
    endtask

    // Expect ectl/eto for the cycle whose inputs were just applied; stall is the running tally.
    task automatic step(input logic [5:0] ectl, input logic eto, input string nm);
        sbq.push_back('{ctl: ectl, to: eto, st: tb_stall, nm: nm});
        if (!ectl[5] && (tb_stall != '1)) tb_stall = tb_stall + CW'(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check({nm, ".rst_ctl"},   32'(ctl_now()),        32'(C_RST));
        check({nm, ".rst_stall"}, 32'(bus.stall_cycles), 32'(0));
        check({nm, ".rst_to"},    32'(bus.imem_timeout), 32'(0));
        rst_n    = 1'b1;
        tb_stall = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0;
        idle();
        tb_stall = '0;

        do_reset("por");
        step(C_NORM, 1'b0, "run0");
        step(C_NORM, 1'b0, "run1");

        // Load-use on rs2, then ex_rd=0, rs1 match, and unused-operand match.
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
        step(C_LDU, 1'b0, "lduse_rs2");
        idle();
        step(C_NORM, 1'b0, "after_lduse");
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_uses_rs1 = 1'b1; bus.id_uses_rs2 = 1'b1;
        step(C_NORM, 1'b0, "rd0_no_stall");
        bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_uses_rs1 = 1'b1; bus.id_uses_rs2 = 1'b0;
        step(C_LDU, 1'b0, "lduse_rs1");
        bus.id_uses_rs1 = 1'b0;
        step(C_NORM, 1'b0, "rs1_unused");
        idle();
        step(C_NORM, 1'b0, "after_rs1");

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check("async.ctl",   32'(ctl_now()),        32'(C_RST));
        check("async.stall", 32'(bus.stall_cycles), 32'(0));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        tb_stall = '0;

        // Branch with a simultaneous load-use, then the flush window.
        bus.ex_branch_taken = 1'b1;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3; bus.id_uses_rs1 = 1'b1;
        step(C_BR, 1'b0, "br_lduse");
        idle();
        step(C_FLR, 1'b0, "flush1");
        step(C_FLR, 1'b0, "flush2");
        step(C_NORM, 1'b0, "flush_done");
        bus.ex_branch_taken = 1'b1;
        step(C_BR, 1'b0, "br2");
        bus.ex_branch_taken = 1'b0; bus.imem_ready = 1'b0;
        step(C_IFW, 1'b0, "flush_wait");
        bus.imem_ready = 1'b1;
        step(C_FLR, 1'b0, "flush_a");
        step(C_FLR, 1'b0, "flush_b");
        step(C_NORM, 1'b0, "flush_b_done");

        // Data-memory stall holding a pending branch.
        do_reset("dst");
        bus.mem_access = 1'b1; bus.dmem_ready = 1'b0; bus.ex_branch_taken = 1'b1;
        repeat (4) step(C_DST, 1'b0, "dstall");
        bus.mem_access = 1'b0; bus.dmem_ready = 1'b1;
        step(C_BR, 1'b0, "dstall_br");
        bus.ex_branch_taken = 1'b0;
        step(C_FLR, 1'b0, "dst_fl1");
        step(C_FLR, 1'b0, "dst_fl2");
        step(C_NORM, 1'b0, "dst_run");

        // Branch abandons an imem wait: the wait count restarts from zero.
        bus.imem_ready = 1'b0;
        repeat (3) step(C_IFW, 1'b0, "iw_pre");
        bus.ex_branch_taken = 1'b1;
        step(C_BR, 1'b0, "iw_br");
        bus.ex_branch_taken = 1'b0; bus.imem_ready = 1'b1;
        step(C_FLR, 1'b0, "iw_fl1");
        step(C_FLR, 1'b0, "iw_fl2");
        step(C_NORM, 1'b0, "iw_run");
        bus.imem_ready = 1'b0;
        repeat (7) step(C_IFW, 1'b0, "iw_post");
        step(C_IFW, 1'b1, "iw_post_to");
        bus.imem_ready = 1'b1;
        step(C_NORM, 1'b1, "iw_post_ret");

        // Eight imem wait cycles: flag visible once the count has reached 7.
        do_reset("imem");
        bus.imem_ready = 1'b0;
        for (int i = 1; i <= 8; i++) step(C_IFW, logic'(i >= 8), "imem_wait");
        bus.imem_ready = 1'b1;
        step(C_NORM, 1'b1, "imem_ret");
        step(C_NORM, 1'b1, "imem_sticky");

        // A dstall inside an imem wait freezes the wait count.
        do_reset("frz");
        bus.imem_ready = 1'b0;
        repeat (3) step(C_IFW, 1'b0, "frz_a");
        bus.mem_access = 1'b1; bus.dmem_ready = 1'b0;
        repeat (2) step(C_DST, 1'b0, "frz_dst");
        bus.mem_access = 1'b0; bus.dmem_ready = 1'b1;
        repeat (4) step(C_IFW, 1'b0, "frz_b");
        step(C_IFW, 1'b1, "frz_to");

        // 2^CW + 3 stall cycles saturate the counter.
        do_reset("sat");
        bus.imem_ready = 1'b0;
        for (int i = 1; i <= 19; i++) step(C_IFW, logic'(i >= 8), "sat_wait");
        bus.imem_ready = 1'b1;
        step(C_NORM, 1'b1, "sat_end");
        step(C_NORM, 1'b1, "sat_hold");

        for (int i = 0; i < 4 && sbq.size() != 0; i++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
